// File: rtl/add_sub_pipe_if.sv
// rtl/add_sub_pipe_if.sv - operand/result bundle for the pipelined adder/subtractor
//
// Purpose: groups the operation request and result signals of add_sub_pipe.
// Ports (signals):
//   in_valid, sub, a, b, stall            driven by the requester (master)
//   out_valid, sum, carry_out, overflow,  driven by the adder (slave)
//   zero, negative
interface add_sub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, sub, a, b, stall,
    input  out_valid, sum, carry_out, overflow, zero, negative
  );

  modport slave (
    input  in_valid, sub, a, b, stall,
    output out_valid, sum, carry_out, overflow, zero, negative
  );
endinterface

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined carry-chained integer adder/subtractor with flags
//
// Purpose: WIDTH-bit a+b / a-b split into STAGES slices of WIDTH/STAGES bits,
// one slice per pipeline stage, one operation accepted per non-stalled cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (clears valids, result and flags)
//   bus    add_sub_pipe_if.slave: in_valid/sub/a/b/stall in,
//          out_valid/sum/carry_out/overflow/zero/negative out
module add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          reset,
  add_sub_pipe_if.slave bus
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("add_sub_pipe: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Pipeline rank k holds an operation about to have slice k computed.
  // B is inverted once at capture and the sub bit becomes the stage-0
  // carry-in, so later ranks only need the carry and the operand bits.
  logic             p_vld [STAGES];
  logic             p_c   [STAGES];
  logic [WIDTH-1:0] p_a   [STAGES];
  logic [WIDTH-1:0] p_b   [STAGES];
  logic [WIDTH-1:0] p_res [STAGES];

  logic [S:0]       slice    [STAGES];
  logic [WIDTH-1:0] res_next [STAGES];
  logic             cin_msb;

  logic [WIDTH-1:0] sum_q;
  logic             out_valid_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, p_a[k][k*S +: S]} + {1'b0, p_b[k][k*S +: S]}
               + {{S{1'b0}}, p_c[k]};
      res_next[k] = p_res[k];
      res_next[k][k*S +: S] = slice[k][S-1:0];
    end
    // sum_msb = a_msb ^ b_msb ^ carry_in_msb, so the carry into the MSB
    // falls out of the final sum without a separate sub-slice adder.
    cin_msb = res_next[L][WIDTH-1] ^ p_a[L][WIDTH-1] ^ p_b[L][WIDTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        p_vld[k] <= 1'b0;
        p_c[k]   <= 1'b0;
        p_a[k]   <= '0;
        p_b[k]   <= '0;
        p_res[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (!bus.stall) begin
      p_vld[0] <= bus.in_valid;
      p_a[0]   <= bus.a;
      p_b[0]   <= bus.sub ? ~bus.b : bus.b;
      p_c[0]   <= bus.sub;
      p_res[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        p_vld[k] <= p_vld[k-1];
        p_a[k]   <= p_a[k-1];
        p_b[k]   <= p_b[k-1];
        p_c[k]   <= slice[k-1][S];
        p_res[k] <= res_next[k-1];
      end
      out_valid_q <= p_vld[L];
      // Result and flags hold the last real result across bubbles.
      if (p_vld[L]) begin
        sum_q   <= res_next[L];
        carry_q <= slice[L][S];
        ovf_q   <= cin_msb ^ slice[L][S];
        zero_q  <= (res_next[L] == '0);
        neg_q   <= res_next[L][WIDTH-1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - directed self-checking bench for add_sub_pipe
module tb_add_sub_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  add_sub_pipe_if #(.WIDTH(32)) if32 ();
  add_sub_pipe_if #(.WIDTH(8))  if8 ();
  add_sub_pipe_if #(.WIDTH(16)) if16 ();

  add_sub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  add_sub_pipe #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .reset(reset), .bus(if8));
  add_sub_pipe #(.WIDTH(16), .STAGES(1)) dut16 (.clk(clk), .reset(reset), .bus(if16));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected {sum, carry, overflow, zero, negative} and the cycle it is due
  logic [35:0] q32[$];
  int          c32[$];
  logic [11:0] q8[$];
  int          c8[$];
  logic [19:0] q16[$];
  int          c16[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [36:0] obs32();
    return {if32.out_valid, if32.sum, if32.carry_out, if32.overflow, if32.zero, if32.negative};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [35:0] e, input int extra, input bit track);
    if32.in_valid = 1'b1;
    if32.a = a;
    if32.b = b;
    if32.sub = s;
    if (track) begin
      q32.push_back(e);
      c32.push_back(cyc + 1 + 4 + extra);
    end
    step();
  endtask

  task automatic idle32(input int n);
    if32.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [11:0] e);
    if8.in_valid = 1'b1;
    if8.a = a;
    if8.b = b;
    if8.sub = s;
    q8.push_back(e);
    c8.push_back(cyc + 1 + 2);
    step();
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [19:0] e);
    if16.in_valid = 1'b1;
    if16.a = a;
    if16.b = b;
    if16.sub = s;
    q16.push_back(e);
    c16.push_back(cyc + 1 + 1);
    step();
  endtask

  // Result consumers: a result counts on out_valid && !stall.
  always @(negedge clk) begin
    if (!reset && if32.out_valid && !if32.stall) begin
      if (q32.size() == 0) check("out32_spurious", 1, 0);
      else begin
        check("out32_result", {if32.sum, if32.carry_out, if32.overflow, if32.zero, if32.negative},
              q32.pop_front());
        check("out32_latency", cyc, c32.pop_front());
      end
    end
    if (!reset && if8.out_valid && !if8.stall) begin
      if (q8.size() == 0) check("out8_spurious", 1, 0);
      else begin
        check("out8_result", {if8.sum, if8.carry_out, if8.overflow, if8.zero, if8.negative},
              q8.pop_front());
        check("out8_latency", cyc, c8.pop_front());
      end
    end
    if (!reset && if16.out_valid && !if16.stall) begin
      if (q16.size() == 0) check("out16_spurious", 1, 0);
      else begin
        check("out16_result", {if16.sum, if16.carry_out, if16.overflow, if16.zero, if16.negative},
              q16.pop_front());
        check("out16_latency", cyc, c16.pop_front());
      end
    end
  end

  initial begin
    logic [36:0] snap;
    if32.in_valid = 1'b0; if32.sub = 1'b0; if32.a = '0; if32.b = '0; if32.stall = 1'b0;
    if8.in_valid  = 1'b0; if8.sub  = 1'b0; if8.a  = '0; if8.b  = '0; if8.stall  = 1'b0;
    if16.in_valid = 1'b0; if16.sub = 1'b0; if16.a = '0; if16.b = '0; if16.stall = 1'b0;

    repeat (2) step();
    check("reset_state32", obs32(), 37'h0);
    check("reset_state8", {if8.out_valid, if8.sum, if8.carry_out, if8.overflow, if8.zero, if8.negative}, 0);
    check("reset_state16", {if16.out_valid, if16.sum, if16.carry_out, if16.overflow, if16.zero, if16.negative}, 0);
    reset = 1'b0;

    // first op: no result on edges 1-3, result after edge 4
    issue32(32'h0000_0000, 32'h0000_0001, 1'b0, {32'h0000_0001, 4'b0000}, 0, 1'b1);
    if32.in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("first_no_valid", if32.out_valid, 1'b0);
    end
    step();
    check("first_valid", if32.out_valid, 1'b1);
    check("first_sum", if32.sum, 32'h0000_0001);
    idle32(2);

    // carry ripple, overflow, subtraction
    issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 4'b1010}, 0, 1'b1);
    issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 4'b0101}, 0, 1'b1);
    issue32(32'h8000_0001, 32'h0000_0002, 1'b1, {32'h7FFF_FFFF, 4'b1100}, 0, 1'b1);
    issue32(32'h0000_0001, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 4'b0001}, 0, 1'b1);
    issue32(32'h1234_5678, 32'h1234_5678, 1'b1, {32'h0000_0000, 4'b1010}, 0, 1'b1);
    idle32(6);

    // eight back-to-back mixed ops
    issue32(32'h427D_316E, 32'h825F_910A, 1'b0, {32'hC4DC_C278, 4'b0001}, 0, 1'b1);
    issue32(32'h0101_0101, 32'hAB90_34C0, 1'b0, {32'hAC91_35C1, 4'b0001}, 0, 1'b1);
    issue32(32'h0000_0005, 32'h0000_0003, 1'b1, {32'h0000_0002, 4'b1000}, 0, 1'b1);
    issue32(32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 4'b1110}, 0, 1'b1);
    issue32(32'h0000_0000, 32'h0000_0001, 1'b1, {32'hFFFF_FFFF, 4'b0001}, 0, 1'b1);
    issue32(32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 4'b1100}, 0, 1'b1);
    issue32(32'h0000_FFFF, 32'h0000_0001, 1'b0, {32'h0001_0000, 4'b0000}, 0, 1'b1);
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 4'b1010}, 0, 1'b1);
    idle32(6);

    // bubble in the stream gives a one-cycle gap
    issue32(32'h0000_0010, 32'h0000_0020, 1'b0, {32'h0000_0030, 4'b0000}, 0, 1'b1);
    idle32(1);
    issue32(32'h0000_0030, 32'h0000_0010, 1'b1, {32'h0000_0020, 4'b1000}, 0, 1'b1);
    idle32(6);

    // stall for 3 cycles right after op0 emerges, op1/op2 in flight
    issue32(32'h1111_1111, 32'h2222_2222, 1'b0, {32'h3333_3333, 4'b0000}, 3, 1'b1);
    issue32(32'hF000_0000, 32'h2000_0000, 1'b0, {32'h1000_0000, 4'b1000}, 3, 1'b1);
    issue32(32'h4000_0000, 32'h4000_0000, 1'b0, {32'h8000_0000, 4'b0101}, 3, 1'b1);
    idle32(2);
    if32.stall = 1'b1;
    if32.in_valid = 1'b1;
    if32.a = 32'hDEAD_BEEF;
    if32.b = 32'h0BAD_F00D;
    snap = obs32();
    check("stall_valid_held", if32.out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_frozen", obs32(), snap);
    end
    if32.stall = 1'b0;
    if32.in_valid = 1'b0;
    repeat (8) step();

    // asynchronous reset between edges with 3 ops in flight
    issue32(32'h0000_0001, 32'h0000_0001, 1'b0, 36'h0, 0, 1'b0);
    issue32(32'h0000_0002, 32'h0000_0002, 1'b0, 36'h0, 0, 1'b0);
    issue32(32'h0000_0003, 32'h0000_0003, 1'b0, 36'h0, 0, 1'b0);
    if32.in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("reset_async", obs32(), 37'h0);
    repeat (2) step();
    reset = 1'b0;
    issue32(32'h0000_0002, 32'h0000_0003, 1'b0, {32'h0000_0005, 4'b0000}, 0, 1'b1);
    idle32(8);

    // WIDTH=8, STAGES=2
    issue8(8'h00, 8'h01, 1'b0, {8'h01, 4'b0000});
    issue8(8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010});
    issue8(8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101});
    issue8(8'h81, 8'h02, 1'b1, {8'h7F, 4'b1100});
    issue8(8'h01, 8'h02, 1'b1, {8'hFF, 4'b0001});
    issue8(8'h34, 8'h34, 1'b1, {8'h00, 4'b1010});
    issue8(8'h0F, 8'h01, 1'b0, {8'h10, 4'b0000});
    if8.in_valid = 1'b0;

    // WIDTH=16, STAGES=1 (latency 1)
    issue16(16'h0000, 16'h0001, 1'b0, {16'h0001, 4'b0000});
    issue16(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 4'b1010});
    issue16(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 4'b0101});
    issue16(16'h8001, 16'h0002, 1'b1, {16'h7FFF, 4'b1100});
    issue16(16'h0001, 16'h0002, 1'b1, {16'hFFFF, 4'b0001});
    issue16(16'h1234, 16'h1234, 1'b1, {16'h0000, 4'b1010});
    if16.in_valid = 1'b0;
    repeat (8) step();

    check("drain32", q32.size(), 0);
    check("drain8", q8.size(), 0);
    check("drain16", q16.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
